alarm_zone_ctrl: RTL and testbench

//  Multi-zone successor of the single door/motion alarm gate. Each zone has a door and a motion sensor.

---
 rtl/alarm_pkg.sv | 17 +
 rtl/sensor_filter.sv | 40 ++++
 rtl/alarm_zone_ctrl.sv | 169 ++++++++++++++++
 tb/tb_alarm_zone_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state type and state encodings for the zone alarm controller.
// The same encodings are used by the panel/indicator logic.
package alarm_pkg;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        PENDING  = 2'd2,
        ALARM    = 2'd3
    } alarm_state_e;

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_PENDING  = 2'd2;
    localparam logic [1:0] ST_ALARM    = 2'd3;

endpackage

// File: rtl/sensor_filter.sv
// One-bit sensor conditioner: two-flop synchroniser followed by a debounce
// filter that only follows the synced input after DEB_CYCLES stable edges.
module sensor_filter #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta;
    logic          synced;
    logic [CW-1:0] cnt;

    // Synchronise, then update filt on the DEB_CYCLES-th differing edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta   <= 1'b0;
            synced <= 1'b0;
            filt   <= 1'b0;
            cnt    <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
            if (synced == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= synced;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm controller: filtered door/motion sensors, arm/disarm FSM
// with sticky zone capture, per-zone disagreement errors. ALARM_ENTRY_DELAY_EN adds an entry delay.
module alarm_zone_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ZONES     = 4,
    parameter int DEB_CYCLES  = 4,
    parameter int ERR_CYCLES  = 16,
    parameter int ENTRY_DELAY = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_ZONES-1:0] door_i,
    input  logic [N_ZONES-1:0] motion_i,
    input  logic               arm_i,
    input  logic               disarm_i,
    input  logic               err_ack_i,
    output logic               armed_o,
    output logic               alarm_o,
    output logic [N_ZONES-1:0] alarm_zone_o,
    output logic               error_o,
    output logic [N_ZONES-1:0] error_zone_o,
    output logic [1:0]         state_o
);

    localparam int EW = $clog2(ERR_CYCLES + 1);
    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_CYCLES - 1);
    localparam logic [EW-1:0] ERR_MAX  = EW'(ERR_CYCLES);

    if (N_ZONES < 1 || N_ZONES > 32) begin : g_bad_zones
        $error("N_ZONES out of range");
    end
    if (DEB_CYCLES < 1 || ERR_CYCLES < 1 || ENTRY_DELAY < 1) begin : g_bad_limits
        $error("cycle limits must be >= 1");
    end

    logic [N_ZONES-1:0] door_f;
    logic [N_ZONES-1:0] motion_f;
    logic [N_ZONES-1:0] trig;
    logic [N_ZONES-1:0] disagree;

    for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
        sensor_filter #(.DEB_CYCLES(DEB_CYCLES)) u_door (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (door_i[z]),
            .filt  (door_f[z])
        );
        sensor_filter #(.DEB_CYCLES(DEB_CYCLES)) u_motion (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (motion_i[z]),
            .filt  (motion_f[z])
        );
    end

    assign trig     = door_f & motion_f;
    assign disagree = door_f ^ motion_f;

    logic [EW-1:0]      err_cnt [N_ZONES];
    logic [N_ZONES-1:0] err_zone;

    // Per-zone disagreement counters; a new set beats a same-edge ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_zone <= '0;
            for (int z = 0; z < N_ZONES; z++) err_cnt[z] <= '0;
        end else begin
            for (int z = 0; z < N_ZONES; z++) begin
                if (disagree[z]) begin
                    if (err_cnt[z] != ERR_MAX) err_cnt[z] <= err_cnt[z] + EW'(1);
                    if (err_cnt[z] >= ERR_LAST) err_zone[z] <= 1'b1;
                end else begin
                    err_cnt[z] <= '0;
                    if (err_ack_i) err_zone[z] <= 1'b0;
                end
            end
        end
    end

    alarm_state_e       state;
    alarm_state_e       state_nxt;
    logic [N_ZONES-1:0] zone;
    logic [N_ZONES-1:0] zone_nxt;

`ifdef ALARM_ENTRY_DELAY_EN
    localparam int DW = $clog2(ENTRY_DELAY + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(ENTRY_DELAY - 1);
    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_nxt;
`endif

    // State, zone capture and entry-delay registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= DISARMED;
            zone  <= '0;
`ifdef ALARM_ENTRY_DELAY_EN
            dwell <= '0;
`endif
        end else begin
            state <= state_nxt;
            zone  <= zone_nxt;
`ifdef ALARM_ENTRY_DELAY_EN
            dwell <= dwell_nxt;
`endif
        end
    end

    // Next state and zone capture; disarm beats arm and trigger.
    always_comb begin
        state_nxt = state;
        zone_nxt  = zone;
`ifdef ALARM_ENTRY_DELAY_EN
        dwell_nxt = '0;
`endif
        case (state)
            DISARMED: begin
                zone_nxt = '0;
                if (arm_i && !disarm_i) state_nxt = ARMED;
            end
            ARMED: begin
                if (disarm_i) begin
                    state_nxt = DISARMED;
                    zone_nxt  = '0;
                end else begin
                    zone_nxt = trig;
`ifdef ALARM_ENTRY_DELAY_EN
                    if (|trig) state_nxt = PENDING;
`else
                    if (|trig) state_nxt = ALARM;
`endif
                end
            end
`ifdef ALARM_ENTRY_DELAY_EN
            PENDING: begin
                if (disarm_i) begin
                    state_nxt = DISARMED;
                    zone_nxt  = '0;
                end else begin
                    zone_nxt = zone | trig;
                    if (dwell == DWELL_LAST) state_nxt = ALARM;
                    else dwell_nxt = dwell + DW'(1);
                end
            end
`endif
            ALARM: begin
                if (disarm_i) begin
                    state_nxt = DISARMED;
                    zone_nxt  = '0;
                end else begin
                    zone_nxt = zone | trig;
                end
            end
            default: begin
                state_nxt = DISARMED;
                zone_nxt  = '0;
            end
        endcase
    end

    assign state_o      = state;
    assign armed_o      = (state_o != ST_DISARMED);
    assign alarm_o      = (state_o == ST_ALARM);
    assign alarm_zone_o = zone;
    assign error_zone_o = err_zone;
    assign error_o      = |err_zone;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: vector table plus hand sequences for reset
// and entry delay, with expected outputs queued per applied stimulus.
module tb_alarm_zone_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] door = '0;
    logic [3:0] motion = '0;
    logic       arm = 1'b0;
    logic       disarm = 1'b0;
    logic       ack = 1'b0;
    logic       armed;
    logic       alarm;
    logic [3:0] alarm_zone;
    logic       error;
    logic [3:0] error_zone;
    logic [1:0] state;

    alarm_zone_ctrl #(
        .N_ZONES     (4),
        .DEB_CYCLES  (4),
        .ERR_CYCLES  (16),
        .ENTRY_DELAY (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .door_i       (door),
        .motion_i     (motion),
        .arm_i        (arm),
        .disarm_i     (disarm),
        .err_ack_i    (ack),
        .armed_o      (armed),
        .alarm_o      (alarm),
        .alarm_zone_o (alarm_zone),
        .error_o      (error),
        .error_zone_o (error_zone),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] door;
        logic [3:0] motion;
        logic       arm;
        logic       disarm;
        logic       ack;
        int         hold;
        logic       armed;
        logic       alarm;
        logic [3:0] zone;
        logic [3:0] err;
        logic [1:0] st;
    } vec_t;

    typedef struct {
        string      name;
        logic       armed;
        logic       alarm;
        logic [3:0] zone;
        logic       err_any;
        logic [3:0] err;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail = 0;

`ifdef ALARM_ENTRY_DELAY_EN
    localparam int FIRE = 39;
`else
    localparam int FIRE = 7;
`endif

    function automatic vec_t mk(string n, logic [3:0] d, logic [3:0] m,
                                logic a, logic ds, logic ak, int h,
                                logic ar, logic al, logic [3:0] z,
                                logic [3:0] er, logic [1:0] st);
        vec_t v;
        v.name = n; v.door = d; v.motion = m;
        v.arm = a; v.disarm = ds; v.ack = ak; v.hold = h;
        v.armed = ar; v.alarm = al; v.zone = z; v.err = er; v.st = st;
        return v;
    endfunction

    task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", n, f, act, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(string n, logic ar, logic al, logic [3:0] z,
                            logic [3:0] er, logic [1:0] st);
        exp_t e;
        e.name = n; e.armed = ar; e.alarm = al; e.zone = z;
        e.err = er; e.err_any = |er; e.st = st;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = sb.pop_front();
        cmp(e.name, "armed", 32'(armed), 32'(e.armed));
        cmp(e.name, "alarm", 32'(alarm), 32'(e.alarm));
        cmp(e.name, "alarm_zone", 32'(alarm_zone), 32'(e.zone));
        cmp(e.name, "error", 32'(error), 32'(e.err_any));
        cmp(e.name, "error_zone", 32'(error_zone), 32'(e.err));
        cmp(e.name, "state", 32'(state), 32'(e.st));
    endtask

    task automatic run_vec(vec_t v);
        door = v.door; motion = v.motion;
        arm = v.arm; disarm = v.disarm; ack = v.ack;
        push_exp(v.name, v.armed, v.alarm, v.zone, v.err, v.st);
        tick(v.hold);
        check_out();
    endtask

    task automatic reset_toggle(string n);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            door = 4'($urandom); motion = 4'($urandom);
            arm = 1'($urandom); disarm = 1'($urandom); ack = 1'($urandom);
            push_exp(n, 1'b0, 1'b0, 4'd0, 4'd0, 2'd0);
            tick(1);
            check_out();
        end
        door = '0; motion = '0; arm = 1'b0; disarm = 1'b0; ack = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        reset_toggle("rst_init");

        tbl.push_back(mk("idle",       4'h0, 4'h0, 0, 0, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("arm",        4'h0, 4'h0, 1, 0, 0,  1, 1, 0, 4'h0, 4'h0, 2'd1));
`ifndef ALARM_ENTRY_DELAY_EN
        tbl.push_back(mk("trig_wait",  4'h4, 4'h4, 0, 0, 0,  6, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("trig_fire",  4'h4, 4'h4, 0, 0, 0,  1, 1, 1, 4'h4, 4'h0, 2'd3));
        tbl.push_back(mk("join_z0",    4'h5, 4'h5, 0, 0, 0,  7, 1, 1, 4'h5, 4'h0, 2'd3));
        tbl.push_back(mk("disarm",     4'h0, 4'h0, 0, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("settle",     4'h0, 4'h0, 0, 0, 0,  7, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("rearm",      4'h0, 4'h0, 1, 0, 0,  1, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("glitch3",    4'h2, 4'h2, 0, 0, 0,  3, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("glitch_rel", 4'h0, 4'h0, 0, 0, 0,  8, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("pulse4",     4'h2, 4'h2, 0, 0, 0,  4, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("pulse_rel",  4'h0, 4'h0, 0, 0, 0,  2, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("pulse_fire", 4'h0, 4'h0, 0, 0, 0,  1, 1, 1, 4'h2, 4'h0, 2'd3));
        tbl.push_back(mk("sticky",     4'h0, 4'h0, 0, 0, 0,  6, 1, 1, 4'h2, 4'h0, 2'd3));
        tbl.push_back(mk("both_alarm", 4'h0, 4'h0, 1, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("both_idle",  4'h0, 4'h0, 1, 1, 0,  2, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("quiet",      4'h0, 4'h0, 0, 0, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("arm2",       4'h0, 4'h0, 1, 0, 0,  1, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("z3_wait",    4'h8, 4'h8, 0, 0, 0,  6, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("dis_trig",   4'h8, 4'h8, 0, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("held_off",   4'h8, 4'h8, 0, 0, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("arm3",       4'h8, 4'h8, 1, 0, 0,  1, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("rearm_fire", 4'h8, 4'h8, 0, 0, 0,  1, 1, 1, 4'h8, 4'h0, 2'd3));
        tbl.push_back(mk("disarm3",    4'h0, 4'h0, 0, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("settle3",    4'h0, 4'h0, 0, 0, 0,  7, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("err_pre",    4'h4, 4'h0, 0, 0, 0, 21, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("err_set",    4'h4, 4'h0, 0, 0, 0,  1, 0, 0, 4'h0, 4'h4, 2'd0));
        tbl.push_back(mk("ack_held",   4'h4, 4'h0, 0, 0, 1,  1, 0, 0, 4'h0, 4'h4, 2'd0));
        tbl.push_back(mk("err_rel",    4'h0, 4'h0, 0, 0, 0,  6, 0, 0, 4'h0, 4'h4, 2'd0));
        tbl.push_back(mk("ack_clr",    4'h0, 4'h0, 0, 0, 1,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("ack_off",    4'h0, 4'h0, 0, 0, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("arm4",       4'h0, 4'h0, 1, 0, 0,  1, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("err_armed",  4'h4, 4'h0, 0, 0, 0, 22, 1, 0, 4'h0, 4'h4, 2'd1));
        tbl.push_back(mk("ack_edge",   4'h0, 4'h0, 0, 0, 1,  6, 1, 0, 4'h0, 4'h4, 2'd1));
        tbl.push_back(mk("ack_clr2",   4'h0, 4'h0, 0, 0, 1,  1, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("disarm4",    4'h0, 4'h0, 0, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
`else
        tbl.push_back(mk("pend_wait",  4'h1, 4'h1, 0, 0, 0,  6, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("pend_enter", 4'h1, 4'h1, 0, 0, 0,  1, 1, 0, 4'h1, 4'h0, 2'd2));
        tbl.push_back(mk("pend_dwell", 4'h1, 4'h1, 0, 0, 0, 31, 1, 0, 4'h1, 4'h0, 2'd2));
        tbl.push_back(mk("pend_fire",  4'h1, 4'h1, 0, 0, 0,  1, 1, 1, 4'h1, 4'h0, 2'd3));
        tbl.push_back(mk("disarm",     4'h0, 4'h0, 0, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("settle",     4'h0, 4'h0, 0, 0, 0,  7, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("rearm",      4'h0, 4'h0, 1, 0, 0,  1, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("pend_wait2", 4'h1, 4'h1, 0, 0, 0,  6, 1, 0, 4'h0, 4'h0, 2'd1));
        tbl.push_back(mk("pend_ent2",  4'h1, 4'h1, 0, 0, 0,  1, 1, 0, 4'h1, 4'h0, 2'd2));
        tbl.push_back(mk("dwell19",    4'h1, 4'h1, 0, 0, 0, 19, 1, 0, 4'h1, 4'h0, 2'd2));
        tbl.push_back(mk("dis_dwell",  4'h1, 4'h1, 0, 1, 0,  1, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("stay_off",   4'h1, 4'h1, 0, 0, 0, 40, 0, 0, 4'h0, 4'h0, 2'd0));
        tbl.push_back(mk("settle2",    4'h0, 4'h0, 0, 0, 0,  7, 0, 0, 4'h0, 4'h0, 2'd0));
`endif

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        run_vec(mk("mid_arm",  4'h0, 4'h0, 1, 0, 0,    1, 1, 0, 4'h0, 4'h0, 2'd1));
        run_vec(mk("mid_fire", 4'h1, 4'h1, 0, 0, 0, FIRE, 1, 1, 4'h1, 4'h0, 2'd3));
        reset_toggle("rst_mid");
        run_vec(mk("post_rst", 4'h0, 4'h0, 0, 0, 0,    8, 0, 0, 4'h0, 4'h0, 2'd0));

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
